// File: rtl/id_stage.sv
// RV64 decode stage: register file, decoder, load-use interlock, ID/EX register.
// Define ID_BYPASS_EN to make a same-cycle writeback visible to operand reads.
module id_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        id_ready,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [63:0] wb_data,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [63:0] ex_a,
  output logic [63:0] ex_b,
  output logic [63:0] ex_imm,
  output logic [5:0]  ex_func,
  output logic [1:0]  ex_op,
  output logic        ex_alusrc,
  output logic [4:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_memtoreg,
  output logic        ex_branch,
  output logic        ex_illegal
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic [63:0] rf [32];

  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic        is_r;
  logic        is_i;
  logic        is_ld;
  logic        is_st;
  logic        is_br;

  assign opcode = instr[6:0];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct3 = instr[14:12];
  assign is_r   = opcode == OP_R;
  assign is_i   = opcode == OP_I;
  assign is_ld  = opcode == OP_LD;
  assign is_st  = opcode == OP_ST;
  assign is_br  = opcode == OP_BR;

  logic [63:0] rs1_val;
  logic [63:0] rs2_val;

  always_comb begin
    rs1_val = rf[rs1];
    rs2_val = rf[rs2];
`ifdef ID_BYPASS_EN
    if (wb_en && wb_rd != 5'd0 && wb_rd == rs1)
      rs1_val = wb_data;
    if (wb_en && wb_rd != 5'd0 && wb_rd == rs2)
      rs2_val = wb_data;
`endif
    if (rs1 == 5'd0)
      rs1_val = '0;
    if (rs2 == 5'd0)
      rs2_val = '0;
  end

  logic [63:0] d_imm;
  logic [5:0]  d_func;
  logic [1:0]  d_op;
  logic        d_alusrc;
  logic        d_regwrite;
  logic        d_memread;
  logic        d_memwrite;
  logic        d_branch;
  logic        d_illegal;
  logic [5:0]  func_alt;
  logic [5:0]  func_std;

  assign func_alt = {2'b00, instr[30], funct3};
  assign func_std = {3'b000, funct3};

  always_comb begin
    d_imm      = '0;
    d_func     = func_std;
    d_op       = 2'b00;
    d_alusrc   = 1'b0;
    d_regwrite = 1'b0;
    d_memread  = 1'b0;
    d_memwrite = 1'b0;
    d_branch   = 1'b0;
    d_illegal  = 1'b0;
    unique case (1'b1)
      is_r: begin
        d_func     = func_alt;
        d_op       = 2'b10;
        d_regwrite = 1'b1;
      end
      is_i: begin
        d_imm      = {{52{instr[31]}}, instr[31:20]};
        // funct3=101 is the shift-right pair, told apart by bit 30
        d_func     = (funct3 == 3'b101) ? func_alt : func_std;
        d_op       = 2'b10;
        d_alusrc   = 1'b1;
        d_regwrite = 1'b1;
      end
      is_ld: begin
        d_imm      = {{52{instr[31]}}, instr[31:20]};
        d_alusrc   = 1'b1;
        d_regwrite = 1'b1;
        d_memread  = 1'b1;
      end
      is_st: begin
        d_imm      = {{52{instr[31]}}, instr[31:25], instr[11:7]};
        d_alusrc   = 1'b1;
        d_memwrite = 1'b1;
      end
      is_br: begin
        d_imm    = {{51{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
        d_op     = 2'b01;
        d_branch = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  logic uses_rs2;
  logic load_use;
  logic advance;

  assign uses_rs2 = is_r || is_st || is_br;
  assign load_use = ex_valid && ex_memread && ex_rd != 5'd0 &&
                    (ex_rd == rs1 || (ex_rd == rs2 && uses_rs2));
  assign advance  = !ex_valid || ex_ready;
  assign id_ready = advance && !load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        rf[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_a        <= '0;
      ex_b        <= '0;
      ex_imm      <= '0;
      ex_func     <= '0;
      ex_op       <= '0;
      ex_alusrc   <= 1'b0;
      ex_rd       <= '0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_branch   <= 1'b0;
      ex_illegal  <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (advance) begin
      // a load-use hazard still loads the slot, but as a bubble
      ex_valid    <= instr_valid && !load_use;
      ex_a        <= rs1_val;
      ex_b        <= rs2_val;
      ex_imm      <= d_imm;
      ex_func     <= d_func;
      ex_op       <= d_op;
      ex_alusrc   <= d_alusrc;
      ex_rd       <= instr[11:7];
      ex_regwrite <= d_regwrite;
      ex_memread  <= d_memread;
      ex_memwrite <= d_memwrite;
      ex_memtoreg <= d_memread;
      ex_branch   <= d_branch;
      ex_illegal  <= d_illegal;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus random traffic
// against a cycle-level reference model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        id_ready;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [63:0] ex_a;
  logic [63:0] ex_b;
  logic [63:0] ex_imm;
  logic [5:0]  ex_func;
  logic [1:0]  ex_op;
  logic        ex_alusrc;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_memtoreg;
  logic        ex_branch;
  logic        ex_illegal;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst_n(rst_n),
    .instr(instr), .instr_valid(instr_valid), .id_ready(id_ready),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_func(ex_func), .ex_op(ex_op), .ex_alusrc(ex_alusrc),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] imm;
    logic [5:0]  func;
    logic [1:0]  op;
    logic        alusrc;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        mtr;
    logic        br;
    logic        ill;
  } exf_t;

  exf_t dut_f;
  assign dut_f = {ex_a, ex_b, ex_imm, ex_func, ex_op, ex_alusrc,
                  ex_rd, ex_regwrite, ex_memread, ex_memwrite,
                  ex_memtoreg, ex_branch, ex_illegal};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  logic [63:0] m_rf [32];
  logic        m_v;
  exf_t        m_ex;

  function automatic exf_t dec(input logic [31:0] i,
                               input logic [63:0] a,
                               input logic [63:0] b);
    exf_t f;
    logic signed [63:0] s;
    f = '0;
    f.a = a;
    f.b = b;
    f.rd = i[11:7];
    f.func = {3'b000, i[14:12]};
    case (i[6:0])
      7'h33: begin
        f.op = 2'd2; f.rw = 1'b1;
        f.func = {2'b00, i[30], i[14:12]};
      end
      7'h13: begin
        f.op = 2'd2; f.rw = 1'b1; f.alusrc = 1'b1;
        s = $signed(i[31:20]); f.imm = s;
        if (i[14:12] == 3'd5) f.func = {2'b00, i[30], i[14:12]};
      end
      7'h03: begin
        f.rw = 1'b1; f.mr = 1'b1; f.mtr = 1'b1; f.alusrc = 1'b1;
        s = $signed(i[31:20]); f.imm = s;
      end
      7'h23: begin
        f.mw = 1'b1; f.alusrc = 1'b1;
        s = $signed({i[31:25], i[11:7]}); f.imm = s;
      end
      7'h63: begin
        f.op = 2'd1; f.br = 1'b1;
        s = $signed({i[31], i[7], i[30:25], i[11:8]});
        f.imm = s * 2;
      end
      default: f.ill = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [63:0] mread(input logic [4:0] idx);
    if (idx == 5'd0) return 64'd0;
`ifdef ID_BYPASS_EN
    if (wb_en && wb_rd == idx) return wb_data;
`endif
    return m_rf[idx];
  endfunction

  function automatic logic m_lu(input logic [31:0] i);
    logic two;
    two = i[6:0] == 7'h33 || i[6:0] == 7'h23 || i[6:0] == 7'h63;
    return m_v && m_ex.mr && m_ex.rd != 5'd0 &&
           (m_ex.rd == i[19:15] || (m_ex.rd == i[24:20] && two));
  endfunction

  task automatic model_reset();
    m_v = 1'b0;
    m_ex = '0;
    for (int k = 0; k < 32; k++) m_rf[k] = '0;
  endtask

  task automatic step(input logic [31:0] i, input logic v,
                      input logic we, input logic [4:0] wr,
                      input logic [63:0] wd, input logic fl,
                      input logic er);
    logic lu;
    @(negedge clk);
    check("ex_valid", ex_valid, m_v);
    if (m_v) check("ex_fields", dut_f, m_ex);
    instr = i; instr_valid = v; wb_en = we; wb_rd = wr;
    wb_data = wd; flush = fl; ex_ready = er;
    #1;
    lu = m_lu(i);
    check("id_ready", id_ready, (!m_v || er) && !lu);
    @(posedge clk);
    if (fl) m_v = 1'b0;
    else if (!m_v || er) begin
      m_ex = dec(i, mread(i[19:15]), mread(i[24:20]));
      m_v = v && !lu;
    end
    if (we && wr != 5'd0) m_rf[wr] = wd;
  endtask

  logic [31:0] ri;

  initial begin
    rst_n = 1'b0;
    instr = '0; instr_valid = 1'b0; wb_en = 1'b0; wb_rd = '0;
    wb_data = '0; flush = 1'b0; ex_ready = 1'b1;
    model_reset();
    #12;
    check("rst_valid", ex_valid, 0);
    check("rst_fields", dut_f, 0);
    @(negedge clk);
    rst_n = 1'b1;

    step(32'h0, 0, 1, 5'd5, 64'h10, 0, 1);
    step(32'h0, 0, 1, 5'd6, 64'h3, 0, 1);
    step(32'h006283B3, 1, 0, 0, 0, 0, 1);
    #2;
    check("add_valid", ex_valid, 1);
    check("add_a", ex_a, 64'h10);
    check("add_b", ex_b, 64'h3);
    check("add_op", ex_op, 2'b10);
    check("add_func", ex_func, 6'b0);
    check("add_rd", ex_rd, 5'd7);
    check("add_rw", ex_regwrite, 1);

    step(32'hFF82B403, 1, 0, 0, 0, 0, 1);
    #2;
    check("ld_imm", ex_imm, 64'hFFFFFFFFFFFFFFF8);
    check("ld_alusrc", ex_alusrc, 1);
    check("ld_mr", ex_memread, 1);
    check("ld_op", ex_op, 2'b00);
    step(32'h001404B3, 1, 0, 0, 0, 0, 1);
    #2;
    check("bubble", ex_valid, 0);
    step(32'h001404B3, 1, 0, 0, 0, 0, 1);
    #2;
    check("after_bubble_v", ex_valid, 1);
    check("after_bubble_rd", ex_rd, 5'd9);

    repeat (3) step(32'h00500093, 1, 0, 0, 0, 0, 0);
    #2;
    check("stall_rd", ex_rd, 5'd9);
    check("stall_ready", id_ready, 0);
    step(32'h00500093, 1, 0, 0, 0, 0, 1);
    #2;
    check("resume_rd", ex_rd, 5'd1);
    check("resume_imm", ex_imm, 64'd5);

    step(32'h006283B3, 1, 1, 5'd3, 64'h33, 1, 1);
    #2;
    check("flush_valid", ex_valid, 0);
    step(32'h000183B3, 1, 0, 0, 0, 0, 1);
    #2;
    check("flush_wb", ex_a, 64'h33);

    step(32'h000283B3, 1, 1, 5'd5, 64'hAA, 0, 1);
    #2;
`ifdef ID_BYPASS_EN
    check("bypass_a", ex_a, 64'hAA);
`else
    check("bypass_a", ex_a, 64'h10);
`endif
    step(32'h0000007F, 1, 0, 0, 0, 0, 1);
    #2;
    check("illegal", ex_illegal, 1);
    check("illegal_rw", ex_regwrite, 0);
    step(32'h0, 0, 1, 5'd0, 64'hFF, 0, 1);
    step(32'h000003B3, 1, 0, 0, 0, 0, 1);
    #2;
    check("x0_a", ex_a, 0);
    check("x0_b", ex_b, 0);

    for (int n = 0; n < 600; n++) begin
      ri = $urandom;
      case ($urandom_range(0, 5))
        0: ri[6:0] = 7'h33;
        1: ri[6:0] = 7'h13;
        2: ri[6:0] = 7'h03;
        3: ri[6:0] = 7'h23;
        4: ri[6:0] = 7'h63;
        default: ri[6:0] = 7'h37;
      endcase
      ri[11:7]  = 5'($urandom_range(0, 7));
      ri[19:15] = 5'($urandom_range(0, 7));
      ri[24:20] = 5'($urandom_range(0, 7));
      step(ri, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
           5'($urandom_range(0, 7)), {$urandom, $urandom},
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end

    step(32'h006283B3, 1, 0, 0, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    #1;
    check("midrst_valid", ex_valid, 0);
    check("midrst_fields", dut_f, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    instr = 32'h006283B3;
    instr_valid = 1'b1;
    wb_en = 1'b0;
    flush = 1'b0;
    ex_ready = 1'b1;
    #1;
    check("midrst_ready", id_ready, 1);
    @(posedge clk);
    m_ex = dec(32'h006283B3, 64'd0, 64'd0);
    m_v = 1'b1;
    #2;
    check("midrst_accept", ex_valid, 1);
    check("midrst_a", ex_a, 0);
    step(32'h0, 0, 0, 0, 0, 0, 1);
    step(32'h0, 0, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
